// File: rtl/seg7_scan_mux_if.sv
// seg7_scan_mux_if: load-side bus of seg7_scan_mux (new digits in, pending flag back)
interface seg7_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    pending;

    modport master (output load, data_in, blank_in, input pending);
    modport slave  (input load, data_in, blank_in, output pending);
endinterface

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: multi-digit 7-segment scanner with frame-aligned double buffering; LEADING_ZERO_BLANK_EN adds leading-zero suppression
module seg7_scan_mux #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 100000,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    seg7_scan_mux_if.slave                              bus,
    output logic [6:0]                                  seg,
    output logic [NUM_DIGITS-1:0]                       an,
    output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
    output logic                                        frame_done
);
    localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW != 0 ? {NUM_DIGITS{1'b1}} : '0;

    logic [CW-1:0]           div_cnt;
    logic [4*NUM_DIGITS-1:0] pend_data, disp_data;
    logic [NUM_DIGITS-1:0]   pend_blank, disp_blank, auto_blank, onehot;
    logic                    tick, wrap, blanked;
    logic [3:0]              nibble;
    logic [6:0]              hex_seg;

    assign tick    = div_cnt == CW'(REFRESH_DIV - 1);
    assign wrap    = tick && digit_idx == DW'(NUM_DIGITS - 1);
    assign nibble  = disp_data[4*digit_idx +: 4];
    assign blanked = disp_blank[digit_idx] | auto_blank[digit_idx];
    assign onehot  = NUM_DIGITS'(1) << digit_idx;

    // Refresh divider and digit scanner; frame_done is registered alongside the wrap to digit 0
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            div_cnt    <= tick ? '0 : div_cnt + 1'b1;
            digit_idx  <= tick ? (wrap ? '0 : digit_idx + 1'b1) : digit_idx;
            frame_done <= wrap;
        end
    end

    // Double buffer: loads land in the pending regs, which move to the display only on a frame wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_data   <= '0;
            pend_blank  <= '0;
            bus.pending <= 1'b0;
            disp_data   <= '0;
            disp_blank  <= '1;
        end else begin
            if (wrap && bus.pending) begin
                disp_data  <= pend_data;
                disp_blank <= pend_blank;
            end
            if (bus.load) begin
                pend_data  <= bus.data_in;
                pend_blank <= bus.blank_in;
            end
            bus.pending <= bus.load || (bus.pending && !wrap);
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_above;

    // Blank digit k>0 when it and every more-significant nibble are zero; digit 0 always shows
    always_comb begin
        zero_above = 1'b1;
        auto_blank = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_above    = zero_above && disp_data[4*k +: 4] == 4'd0;
            auto_blank[k] = zero_above;
        end
    end
`else
    assign auto_blank = '0;
`endif

    // Hex nibble to active-low {g,f,e,d,c,b,a}
    always_comb begin
        case (nibble)
            4'h0: hex_seg = 7'b1000000;
            4'h1: hex_seg = 7'b1111001;
            4'h2: hex_seg = 7'b0100100;
            4'h3: hex_seg = 7'b0110000;
            4'h4: hex_seg = 7'b0011001;
            4'h5: hex_seg = 7'b0010010;
            4'h6: hex_seg = 7'b0000010;
            4'h7: hex_seg = 7'b1111000;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0010000;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b0000011;
            4'hC: hex_seg = 7'b1000110;
            4'hD: hex_seg = 7'b0100001;
            4'hE: hex_seg = 7'b0000110;
            default: hex_seg = 7'b0001110;
        endcase
    end

    // Registered pin stage: one cycle behind digit_idx so segments and anode switch together
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= 7'h7F;
            an  <= AN_OFF;
        end else begin
            seg <= blanked ? 7'h7F : hex_seg;
            an  <= AN_ACTIVE_LOW != 0 ? ~onehot : onehot;
        end
    end
endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Parametrised time-multiplexed driver for a common-anode multi-digit 7-segment display; successor to the single-digit select-to-pattern decoder.
- Holds NUM_DIGITS hex nibbles, decodes each to active-low segments and scans anodes at a programmable refresh rate.
- New values are double-buffered and committed only at frame boundaries, so the display never tears.
- Sits between board-level counters/status logic and the FPGA seg/anode pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (>=1).
- REFRESH_DIV, 100000, clk cycles each digit is lit (>=1).
- AN_ACTIVE_LOW, 1, 1 = anode enables driven low-active; 0 = high-active.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  single-cycle strobe; captures data_in/blank_in into pending buffer.
- data_in  input  4*NUM_DIGITS  nibble k = digit k (bits [4k+3:4k]); digit 0 = rightmost.
- blank_in  input  NUM_DIGITS  bit k = 1 blanks digit k.
- seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- an  output  NUM_DIGITS  one-hot anode enable, polarity per AN_ACTIVE_LOW.
- digit_idx  output  max(1,$clog2(NUM_DIGITS))  digit currently selected by scanner.
- pending  output  1  high while a loaded value awaits commit.
- frame_done  output  1  one-cycle pulse when scan wraps from last digit to digit 0.

Behaviour:
- Reset (rst=1 at clk edge): div counter=0, digit_idx=0, pending=0, frame_done=0, display and pending data regs=0, display blank reg=all 1s, seg=7'b1111111, an=all digits off. Reset mid-scan or mid-pending discards everything.
- Divider: counts 0..REFRESH_DIV-1; at terminal count wraps to 0 and digit_idx advances by 1; from NUM_DIGITS-1 wraps to 0. REFRESH_DIV=1 advances every cycle.
- frame_done: asserted exactly in the cycle after digit_idx changes NUM_DIGITS-1 -> 0 (registered with the wrap); NUM_DIGITS=1 pulses every REFRESH_DIV cycles.
- Load: load=1 -> pending data/blank regs <= data_in/blank_in, pending<=1. Several loads before commit: last wins.
- Commit: on the edge where digit_idx wraps to 0, if pending=1, display regs <= pending regs and pending<=0.
- Simultaneous load and wrap on the same edge: the previously pending value (if any) commits; the new value is captured and pending stays 1 until the next wrap.
- Output stage registered: seg/an reflect digit_idx and display regs with 1-cycle latency (digit_idx=k at edge t -> an/seg show digit k after edge t+1).
- an: only bit digit_idx active; all others inactive. Never two bits active.
- seg: blanked digit -> 7'b1111111 (anode still asserted). Otherwise hex decode: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
- load ignored while rst=1.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: any digit k>0 whose nibble and every higher nibble in the display reg are 0 is additionally blanked (ORed with blank reg); digit 0 never auto-blanked. Value 0x0007 shows "   7"; 0x0000 shows "   0".
- Undefined: only blank reg controls blanking; 0x0007 shows "0007".

Test Plan:
- NUM_DIGITS=4, REFRESH_DIV=4: release reset -> seg=1111111 for a full frame, an rotates 1110,1101,1011,0111 every 4 cycles, frame_done pulses every 16 cycles.
- load data_in=16'h12AF, blank_in=0 mid-frame -> pending=1, display unchanged until wrap; next frame seg on digits 0..3 = 0001110,0001000,0100100,1111001; pending=0.
- Two loads (16'h1111 then 16'h2222) in one frame -> only 2222 displayed after wrap.
- load 16'h3333 coincident with wrap edge while 16'h1111 pending -> 1111 shows this frame, 3333 next frame.
- blank_in=4'b1010 with 16'h8888 -> digits 1,3 seg=1111111, digits 0,2 seg=0000000; rst mid-frame -> all blank, digit_idx=0 next cycle.
- With LEADING_ZERO_BLANK_EN, load 16'h0050 -> digits 3,2 blank, digit 1 = 0010010, digit 0 = 1000000.
